// File: rtl/arb_in_fifo.sv
// arb_in_fifo: per-lane FWFT input buffer feeding one request lane of the round-robin arbiter.
// Latency: a word pushed at edge N is presented on out_valid/out_data right after edge N (no bypass).
// Backpressure: in_ready drops at count == DEPTH (no pass-through on full); out_valid/out_data hold while out_ready is low.
//
// Ports:
//   clk, rst            single clock; asynchronous active-low reset
//   flush               synchronous clear of pointers/count, beats any push or pop that cycle
//   in_valid/in_ready/in_data     producer side (push = in_valid & in_ready)
//   out_valid/out_ready/out_data  arbiter side (pop = out_valid & out_ready), out_data read combinationally
//   count               current occupancy, 0..DEPTH
//   almost_full         count >= AF_LEVEL; only present when ARB_IN_FIFO_AF_EN is defined
//
// Parameters: DW word width, DEPTH entries (power of two, >= 2), AF_LEVEL almost-full threshold (1..DEPTH).
module arb_in_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [$clog2(DEPTH):0] count
`ifdef ARB_IN_FIFO_AF_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_in_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic push;
  logic pop;

  // Flow-control flags come straight from the registered count, so there is
  // no combinational path from out_ready to in_ready or from in_valid to
  // out_valid. A full FIFO refuses a push even when a pop happens that cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // First-word-fall-through: the head entry is always on out_data. Only the
  // read pointer selects it, and it only moves on a pop, so the word stays
  // stable while the arbiter holds out_ready low.
  assign out_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over everything; any push/pop this cycle is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write; a push coinciding with flush is discarded.
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Array has no reset: its contents are only ever observed through
  // out_data while count is non-zero, i.e. after they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ARB_IN_FIFO_AF_EN
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("arb_in_fifo: AF_LEVEL must be in 1..DEPTH");
  end

  // Derived from registered count, so it moves on the same edge as count.
  assign almost_full = (count_q >= CW'(AF_LEVEL));
`else
  // Almost-full is compiled out; AF_LEVEL has no effect in this build and is
  // referenced here only so the parameter is accepted without complaint.
  if (AF_LEVEL < 0) begin : g_af_level_ignored
  end
`endif

endmodule

// File: tb/tb_arb_in_fifo.sv
module tb_arb_in_fifo;

  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
`ifdef ARB_IN_FIFO_AF_EN
  logic          almost_full;
`endif

  int errors = 0;
  int checks = 0;

  // Scoreboard: words the bench expects to see, in order.
  logic [DW-1:0] exp_q[$];
  int            mdl_cnt = 0;

  always #5 clk = ~clk;

  arb_in_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef ARB_IN_FIFO_AF_EN
    ,
    .almost_full (almost_full)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare status outputs against the model.
  task automatic check_status();
    check("in_ready",  32'(in_ready),  32'(mdl_cnt != DEPTH));
    check("out_valid", 32'(out_valid), 32'(mdl_cnt != 0));
    check("count",     32'(count),     32'(mdl_cnt));
`ifdef ARB_IN_FIFO_AF_EN
    check("almost_full", 32'(almost_full), 32'(mdl_cnt >= AF_LEVEL));
`endif
    if (mdl_cnt != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
  endtask

  // Inputs are already set (on the low phase). Check, take one rising edge,
  // update the model, then return on the next falling edge and check again.
  task automatic step();
    bit do_push;
    bit do_pop;
    check_status();
    do_push = in_valid && (mdl_cnt != DEPTH);
    do_pop  = out_ready && (mdl_cnt != 0);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (do_pop)  begin void'(exp_q.pop_front()); mdl_cnt--; end
      if (do_push) begin exp_q.push_back(in_data); mdl_cnt++; end
    end
    @(negedge clk);
    check_status();
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
`ifdef ARB_IN_FIFO_AF_EN
    check("rst_almost_full", 32'(almost_full), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill with out_ready low: count 1..4, head stays 0x11.
    foreach (exp_q[i]) ; // queue empty here
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i * 8'h11), 0, 0);
      step();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);

    // Full refusal: pop 0x11, 0x55 is refused.
    drive(1, 8'h55, 1, 0);
    step();
    check("refuse_count", 32'(count), 32'd3);
    // 0x55 accepted next cycle.
    drive(1, 8'h55, 0, 0);
    step();
    check("accept_count", 32'(count), 32'd4);
    // Drain 0x22, 0x33, 0x44, 0x55.
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0);
      step();
    end

    // Streaming at count == 1, crossing the pointer wrap.
    drive(1, 8'hA0, 0, 0);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 1, 0);
      step();
      check("stream_count", 32'(count), 32'd1);
    end
    drive(0, 8'h00, 1, 0);
    step();

    // Back-pressure hold for 5 cycles.
    drive(1, 8'h3C, 0, 0);
    step();
    drive(1, 8'hC3, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 0, 0);
      step();
      check("hold_data", 32'(out_data), 32'h3C);
    end
    // Drain one, leaving one word for the flush test.
    drive(0, 8'h00, 1, 0);
    step();

    // Flush with count = 3 alongside a push and a pop.
    drive(1, 8'h71, 0, 0);
    step();
    drive(1, 8'h72, 0, 0);
    step();
    check("pre_flush_count", 32'(count), 32'd3);
    drive(1, 8'h99, 1, 1);
    step();
    check("flush_count",     32'(count),     32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    drive(1, 8'hAA, 0, 0);
    step();
    check("post_flush_data", 32'(out_data), 32'hAA);

    // Async reset mid-cycle with count = 2.
    drive(1, 8'hBB, 0, 0);
    step();
    drive(0, 8'h00, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_count",     32'(count),     32'd0);
    check("async_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Traffic after reset, then almost_full edges (checked in step when enabled).
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h5A + i), 0, 0);
      step();
    end
    drive(0, 8'h00, 1, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h00, 1, 0);
      step();
    end
    drive(0, 8'h00, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_in_fifo.md
# arb_in_fifo

Per-requester input buffer that sits directly upstream of the round-robin arbiter: one instance per request lane, its output handshake driving that lane's `valid_in` bit and `DW`-bit `data_in` slice, and taking that lane's `ready_out` bit back as `out_ready`. It decouples a bursty producer from arbitration latency by holding up to `DEPTH` words in a first-word-fall-through FIFO. The arbiter sees a clean valid/ready source whose valid never drops while a word is pending.

## Interface
- `DW`, 8, data word width; must match the arbiter's `DW`
- `DEPTH`, 4, storage entries; power of two, ≥ 2
- `AF_LEVEL`, 3, almost-full threshold, 1..DEPTH; used only when `ARB_IN_FIFO_AF_EN` is defined
- `clk` input 1 — single clock; all state updates on rising edge
- `rst` input 1 — asynchronous, active-low reset
- `flush` input 1 — synchronous clear of contents, active high
- `in_valid` input 1 — producer has a word
- `in_ready` output 1 — FIFO can accept a word
- `in_data` input DW — producer word
- `out_valid` output 1 — to arbiter `valid_in[i]`
- `out_ready` input 1 — from arbiter `ready_out[i]`
- `out_data` output DW — to arbiter `data_in[i*DW +: DW]`
- `count` output $clog2(DEPTH)+1 — current occupancy, 0..DEPTH
- `almost_full` output 1 — present only with `ARB_IN_FIFO_AF_EN`

## Operation
- Storage: `DEPTH`×`DW` register array, write pointer and read pointer of $clog2(DEPTH) bits each, and an occupancy counter of $clog2(DEPTH)+1 bits.
- Pointers wrap from DEPTH-1 to 0 by natural overflow.
- push = `in_valid & in_ready`: write `in_data` at the write pointer, then advance the write pointer.
- pop = `out_valid & out_ready`: advance the read pointer.
- `count` update:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop in the same cycle
- `in_ready` = (`count` != DEPTH). A full FIFO refuses a push even if a pop occurs in the same cycle; there is no pass-through on full.
- `out_valid` = (`count` != 0).
- `out_data` = array entry at the read pointer, combinational (FWFT). When `out_valid` = 0, `out_data` is don't-care, and the bench must not check it.
- Empty FIFO: a push is accepted and no pop is possible that cycle. There is no same-cycle bypass.
- Holding rule: while `out_valid` = 1 and `out_ready` = 0, `out_valid` and `out_data` stay stable. This is required by the arbiter's grant-hold behaviour.
- `flush` = 1 at a clock edge:
  - pointers and `count` go to 0; array contents are not cleared
  - any push or pop that cycle is discarded
  - `flush` takes priority over all other events
- Reset (`rst` low, any time, including mid-transfer): pointers = 0, `count` = 0, so `in_ready` = 1 and `out_valid` = 0 immediately, without waiting for a clock edge. Array contents are not reset.

## Timing
- Write-to-read latency: a word pushed at edge N is visible with `out_valid` = 1 after edge N.
- Throughput: sustained 1 push and 1 pop per cycle when 0 < `count` < DEPTH.
- `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Outputs in reset: `in_ready` = 1, `out_valid` = 0, `count` = 0, `almost_full` = 0.

## Configuration
- `ARB_IN_FIFO_AF_EN` defined:
  - adds the `almost_full` output port
  - `almost_full` = (`count` >= `AF_LEVEL`), derived from registered `count`, so it updates in the same cycle as `count`
  - producers use it for early back-pressure
- Not defined: no `almost_full` port, no associated logic; `AF_LEVEL` is ignored.

## Test plan
- Reset then fill (DEPTH=4, DW=8):
  - push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready` = 0 → `count` steps 1,2,3,4
  - `in_ready` = 0 after the 4th edge
  - `out_data` = 0x11 throughout
- Full refusal:
  - with FIFO full, `in_valid` = 1 with 0x55 and `out_ready` = 1 for one cycle → 0x11 popped, 0x55 not written, `count` = 3
  - next cycle 0x55 is accepted, `count` = 4
  - drain order: 0x22, 0x33, 0x44, 0x55
- Streaming:
  - with `count` = 1, push and pop every cycle for 8 cycles with values 0x01..0x08 → `count` stays 1
  - outputs appear in order with exactly one cycle of lag
  - pointer wrap crossed at least once
- Back-pressure hold: with `out_valid` = 1, hold `out_ready` = 0 for 5 cycles → `out_valid` and `out_data` unchanged every cycle.
- Flush and reset:
  - with `count` = 3, assert `flush` together with a push and a pop → `count` = 0, `out_valid` = 0
  - then push 0xAA → `out_data` = 0xAA after one edge
  - with `count` = 2, assert `rst` low between clock edges → `out_valid` and `count` clear immediately
- Macro on, AF_LEVEL=3: push 3 words → `almost_full` rises on the 3rd edge; pop 1 word → `almost_full` falls on that edge.
